// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - Shared types, constants and address helpers for the cache writeback path.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wb_state_t;

    localparam int BEAT_WIDTH = 64;

    function automatic int burst_size(input int offset_bits);
        return (2 ** offset_bits) / (BEAT_WIDTH / 8);
    endfunction

    function automatic logic [31:0] line_address(input logic [31:0] tag_v,
                                                 input logic [31:0] index_v,
                                                 input int          index_bits,
                                                 input int          offset_bits);
        return (tag_v << (index_bits + offset_bits)) | (index_v << offset_bits);
    endfunction

endpackage

// File: rtl/writeback_lane_buffer.sv
// rtl/writeback_lane_buffer.sv - Snapshot register for the victim lane with beat and bypass-word muxes.
// WRITEBACK_BYPASS_EN adds the 32-bit word read port.
module writeback_lane_buffer
    import cache_pkg::*;
#(
    parameter int LANE_W = 512,
    parameter int SEL_W  = 3
`ifdef WRITEBACK_BYPASS_EN
    ,
    parameter int OFF_W  = 6
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_load,
    input  logic [LANE_W-1:0]     i_lane,
    input  logic [SEL_W-1:0]      i_beat_sel,
    output logic [BEAT_WIDTH-1:0] o_beat_data
`ifdef WRITEBACK_BYPASS_EN
    ,
    input  logic [OFF_W-1:0]      i_byte_off,
    output logic [31:0]           o_word_data
`endif
);

    // Data-only storage: contents are meaningless until the first load.
    logic [LANE_W-1:0] r_lane;

    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_lane <= i_lane;
        end
    end

    assign o_beat_data = r_lane[BEAT_WIDTH*int'(i_beat_sel) +: BEAT_WIDTH];

`ifdef WRITEBACK_BYPASS_EN
    // Word-aligned: the low two byte-offset bits are dropped by the shift.
    assign o_word_data = r_lane[32*int'(i_byte_off >> 2) +: 32];
`endif

endmodule

// File: rtl/data_cache_writeback.sv
// rtl/data_cache_writeback.sv - Avalon-MM burst-write engine evicting one dirty cache lane.
// Optional WRITEBACK_BYPASS_EN adds a tag/index matched read port into the evicting lane.
module data_cache_writeback
    import cache_pkg::*;
#(
    parameter int bits_for_index   = 6,
    parameter int bits_for_offset  = 6,
    parameter int bits_for_tag     = 32 - bits_for_index - bits_for_offset,
    parameter int single_lane_size = 8 * (2 ** bits_for_offset)
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic [31:0]                 memory_address,
    output logic                        memory_write,
    output logic [63:0]                 memory_writedata,
    output logic [7:0]                  memory_byteenable,
    output logic [3:0]                  memory_burstcount,
    input  logic                        memory_waitrequest,
    input  logic [bits_for_tag-1:0]     tag,
    input  logic [bits_for_index-1:0]   index,
    input  logic [single_lane_size-1:0] lane_to_memory,
    input  logic                        start_transfer,
`ifdef WRITEBACK_BYPASS_EN
    input  logic [bits_for_tag-1:0]     bypass_tag,
    input  logic [bits_for_index-1:0]   bypass_index,
    input  logic [bits_for_offset-1:0]  bypass_offset,
    output logic [31:0]                 bypass_data,
    output logic                        bypass_hit,
`endif
    output logic                        busy,
    output logic                        data_done
);

    localparam int                 BURST     = burst_size(bits_for_offset);
    localparam int                 CNT_W     = bits_for_offset - 3;
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BURST - 1);

    wb_state_t                 r_state;
    logic [CNT_W-1:0]          r_count;
    logic [bits_for_tag-1:0]   r_tag;
    logic [bits_for_index-1:0] r_index;
    logic                      r_write;
    logic                      r_busy;
    logic                      r_done;
    logic                      w_load;
    logic                      w_accept;

    assign w_load   = (r_state == ST_IDLE) && start_transfer;
    assign w_accept = r_write && !memory_waitrequest;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_tag   <= '0;
            r_index <= '0;
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_transfer) begin
                        r_tag   <= tag;
                        r_index <= index;
                        r_count <= '0;
                        r_write <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_accept) begin
                        if (r_count == LAST_BEAT) begin
                            r_write <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_write <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign memory_address    = line_address(32'(r_tag), 32'(r_index), bits_for_index, bits_for_offset);
    assign memory_write      = r_write;
    assign memory_byteenable = 8'hFF;
    assign memory_burstcount = 4'(BURST);
    assign busy              = r_busy;
    assign data_done         = r_done;

    writeback_lane_buffer #(
        .LANE_W (single_lane_size),
        .SEL_W  (CNT_W)
`ifdef WRITEBACK_BYPASS_EN
        ,
        .OFF_W  (bits_for_offset)
`endif
    ) u_lane_buffer (
        .i_clk       (clock),
        .i_load      (w_load),
        .i_lane      (lane_to_memory),
        .i_beat_sel  (r_count),
        .o_beat_data (memory_writedata)
`ifdef WRITEBACK_BYPASS_EN
        ,
        .i_byte_off  (bypass_offset),
        .o_word_data (bypass_data)
`endif
    );

`ifdef WRITEBACK_BYPASS_EN
    assign bypass_hit = r_busy && (bypass_tag == r_tag) && (bypass_index == r_index);
`endif

endmodule

// File: tb/tb_data_cache_writeback.sv
// tb/tb_data_cache_writeback.sv - Randomized self-checking bench for data_cache_writeback.
// Exercises WRITEBACK_BYPASS_EN ports when that macro is defined.
module tb_data_cache_writeback;

    logic         clock = 1'b0;
    logic         reset;
    logic [31:0]  memory_address;
    logic         memory_write;
    logic [63:0]  memory_writedata;
    logic [7:0]   memory_byteenable;
    logic [3:0]   memory_burstcount;
    logic         memory_waitrequest;
    logic [19:0]  tag;
    logic [5:0]   index;
    logic [511:0] lane_to_memory;
    logic         start_transfer;
    logic         busy;
    logic         data_done;
`ifdef WRITEBACK_BYPASS_EN
    logic [19:0]  bypass_tag;
    logic [5:0]   bypass_index;
    logic [5:0]   bypass_offset;
    logic [31:0]  bypass_data;
    logic         bypass_hit;
`endif

    always #5 clock = ~clock;

    data_cache_writeback dut (
        .clock              (clock),
        .reset              (reset),
        .memory_address     (memory_address),
        .memory_write       (memory_write),
        .memory_writedata   (memory_writedata),
        .memory_byteenable  (memory_byteenable),
        .memory_burstcount  (memory_burstcount),
        .memory_waitrequest (memory_waitrequest),
        .tag                (tag),
        .index              (index),
        .lane_to_memory     (lane_to_memory),
        .start_transfer     (start_transfer),
`ifdef WRITEBACK_BYPASS_EN
        .bypass_tag         (bypass_tag),
        .bypass_index       (bypass_index),
        .bypass_offset      (bypass_offset),
        .bypass_data        (bypass_data),
        .bypass_hit         (bypass_hit),
`endif
        .busy               (busy),
        .data_done          (data_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [511:0] rand_lane();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // mode: 0 no stalls, 1 three-cycle stalls on beats 0 and 5, 2 random stalls.
    // Cycle 0 is the cycle start_transfer is presented; outputs are observed at each negedge.
    task automatic do_burst(input logic [19:0] t, input logic [5:0] ix, input logic [511:0] ln,
                            input int mode, input int busy_start, input int rst_after,
                            output int done_cycle);
        logic [31:0] exp_addr;
        int  k, st, last_c, dut_acc;
        logic w;
        bit  finished;
        exp_addr   = 32'(t) * 32'd4096 + 32'(ix) * 32'd64;
        k = 0; st = 0; last_c = -10; dut_acc = 0; finished = 0; done_cycle = -1;
        tag = t; index = ix; lane_to_memory = ln; start_transfer = 1'b1; memory_waitrequest = 1'b0;
        for (int c = 1; c < 60; c++) begin
            @(negedge clock);
            if (k < 8) begin
                check("write", 64'(memory_write), 64'd1);
                check("wdata", memory_writedata, ln[64*k +: 64]);
                check("addr", 64'(memory_address), 64'(exp_addr));
                check("busy", 64'(busy), 64'd1);
                check("done_early", 64'(data_done), 64'd0);
                check("burstcount", 64'(memory_burstcount), 64'd8);
                check("byteenable", 64'(memory_byteenable), 64'hFF);
`ifdef WRITEBACK_BYPASS_EN
                if (c == 3) begin
                    bypass_tag = t; bypass_index = ix; bypass_offset = 6'h2C;
                    #1;
                    check("bypass_hit", 64'(bypass_hit), 64'd1);
                    check("bypass_data", 64'(bypass_data), 64'(ln[64*5+32 +: 32]));
                    bypass_index = ix ^ 6'h01;
                    #1;
                    check("bypass_miss", 64'(bypass_hit), 64'd0);
                    bypass_index = ix;
                end
`endif
            end else if (c == last_c + 1) begin
                check("done", 64'(data_done), 64'd1);
                check("write_after", 64'(memory_write), 64'd0);
                check("busy_done", 64'(busy), 64'd1);
                done_cycle = c;
            end else begin
                check("done_clear", 64'(data_done), 64'd0);
                check("busy_idle", 64'(busy), 64'd0);
                check("write_idle", 64'(memory_write), 64'd0);
`ifdef WRITEBACK_BYPASS_EN
                #1;
                check("bypass_idle", 64'(bypass_hit), 64'd0);
`endif
                if (c == last_c + 3) begin
                    finished = 1;
                    break;
                end
            end
            // Drive this cycle's inputs; the lane/tag/index inputs get scrambled after start.
            start_transfer = (c == busy_start);
            tag   = 20'($urandom);
            index = 6'($urandom);
            lane_to_memory = rand_lane();
            if (k < 8) begin
                if (mode == 1) begin
                    if ((k == 0 || k == 5) && st < 3) begin w = 1'b1; st++; end
                    else begin w = 1'b0; st = 0; end
                end else if (mode == 2) w = ($urandom_range(0, 2) == 0);
                else w = 1'b0;
            end else w = 1'b0;
            memory_waitrequest = w;
            if (memory_write && !w) dut_acc++;
            if (rst_after >= 0 && k == rst_after) begin
                memory_waitrequest = 1'b0;
                #2 reset = 1'b1;
                #1;
                check("rst_write", 64'(memory_write), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_addr", 64'(memory_address), 64'd0);
                @(negedge clock);
                reset = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clock);
                    check("post_rst_write", 64'(memory_write), 64'd0);
                    check("post_rst_done", 64'(data_done), 64'd0);
                    check("post_rst_busy", 64'(busy), 64'd0);
                end
                return;
            end
            if (k < 8 && !w) begin
                k++;
                if (k == 8) last_c = c;
            end
        end
        start_transfer = 1'b0;
        check("burst_finished", 64'(finished), 64'd1);
        check("beats_accepted", 64'(dut_acc), 64'd8);
    endtask

    initial begin
        logic [511:0] ln;
        int dc;
        reset = 1'b1;
        memory_waitrequest = 1'b0;
        tag = '0; index = '0; lane_to_memory = '0; start_transfer = 1'b0;
`ifdef WRITEBACK_BYPASS_EN
        bypass_tag = '0; bypass_index = '0; bypass_offset = '0;
`endif
        repeat (2) @(negedge clock);
        check("reset_write", 64'(memory_write), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(data_done), 64'd0);
        check("reset_addr", 64'(memory_address), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_busy", 64'(busy), 64'd0);

        for (int k = 0; k < 8; k++) ln[64*k +: 64] = 64'h1111_0000_0000_0000 * 64'(k);
        do_burst(20'hABCDE, 6'h15, ln, 0, -1, -1, dc);
        check("basic_done_cycle", 64'(dc), 64'd9);

        do_burst(20'h12345, 6'h2A, rand_lane(), 1, -1, -1, dc);
        check("stall_done_cycle", 64'(dc), 64'd15);

        do_burst(20'h0F0F0, 6'h03, rand_lane(), 0, 4, -1, dc);
        check("busy_start_done_cycle", 64'(dc), 64'd9);
        do_burst(20'hF0F0F, 6'h3C, rand_lane(), 0, -1, -1, dc);
        check("second_done_cycle", 64'(dc), 64'd9);

        for (int i = 0; i < 6; i++)
            do_burst(20'($urandom), 6'($urandom), rand_lane(), 2, -1, -1, dc);

        do_burst(20'h5A5A5, 6'h11, rand_lane(), 0, -1, 3, dc);
        do_burst(20'hC3C3C, 6'h22, rand_lane(), 2, -1, -1, dc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
